encoder_42_hs: RTL and testbench

- Registered one-hot-to-binary encoder. It is the inverse of the team's 2-to-4 one-hot decoder, and together the two form a select-line round trip.
- Accepts an N-bit one-hot word over a valid/ready handshake and emits its binary index plus error flags over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under backpressure.
- A saturating counter tallies malformed inputs (all-zero or multi-hot) for debug readout.

---
 rtl/encdec_pkg.sv | 20 ++
 rtl/onehot_enc.sv | 39 +++
 rtl/encoder_42_hs.sv | 117 +++++++++++
 tb/tb_encoder_42_hs.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/encdec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : encdec_pkg
// Brief   : Widths and helpers shared by the 2-to-4 decoder and its encoder.
// Revision: 1.0
// ============================================================================
package encdec_pkg;

  localparam int SEL_W = 2;
  localparam int SEL_N = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_enc.sv
`default_nettype none
// ============================================================================
// Module  : onehot_enc
// Brief   : Combinational one-hot to binary encoder with zero/multi-hot flags.
// Revision: 1.0
// ============================================================================
module onehot_enc
  import encdec_pkg::*;
#(
  parameter int N         = 4,
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic [N-1:0]          val,
  output logic [clog2(N)-1:0]   idx,
  output logic                  zero,
  output logic                  multi
);

  localparam int W = clog2(N);

  logic w_found;

  // Scan upward: with PRIO_HIGH the last hit wins, otherwise the first hit is kept.
  always_comb begin
    idx     = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (val[i] && (PRIO_HIGH || !w_found)) begin
        idx     = i[W-1:0];
        w_found = 1'b1;
      end
    end
  end

  assign zero  = (val == '0);
  assign multi = |(val & (val - N'(1)));

endmodule
`default_nettype wire

// File: rtl/encoder_42_hs.sv
`default_nettype none
// ============================================================================
// Module  : encoder_42_hs
// Brief   : Registered one-hot encoder with valid/ready skid buffer and
//           saturating malformed-input counter.
// Revision: 1.0
// ============================================================================
module encoder_42_hs
  import encdec_pkg::*;
#(
  parameter int N         = 4,
  parameter bit PRIO_HIGH = 1'b1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          val,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [clog2(N)-1:0]   y,
  output logic                  y_zero,
  output logic                  y_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  err_clr,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int W = clog2(N);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic [W-1:0]         w_idx;
  logic                 w_zero;
  logic                 w_multi;
  logic                 w_err;
  logic                 w_accept;
  logic                 w_or_free;

  logic                 r_or_valid;
  logic [W-1:0]         r_or_y;
  logic                 r_or_zero;
  logic                 r_or_err;
  logic                 r_sk_valid;
  logic [W-1:0]         r_sk_y;
  logic                 r_sk_zero;
  logic                 r_sk_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  onehot_enc #(
    .N         (N),
    .PRIO_HIGH (PRIO_HIGH)
  ) u_enc (
    .val   (val),
    .idx   (w_idx),
    .zero  (w_zero),
    .multi (w_multi)
  );

  assign w_err     = w_zero | w_multi;
  assign w_accept  = in_valid & in_ready;
  assign w_or_free = ~r_or_valid | out_ready;

  // The skid entry only ever fills while OR is stalled, so its empty flag is
  // a registered ready with no path from out_ready.
  assign in_ready  = ~r_sk_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_or_valid <= 1'b0;
      r_or_y     <= '0;
      r_or_zero  <= 1'b0;
      r_or_err   <= 1'b0;
      r_sk_valid <= 1'b0;
      r_sk_y     <= '0;
      r_sk_zero  <= 1'b0;
      r_sk_err   <= 1'b0;
    end else if (w_or_free) begin
      if (r_sk_valid) begin
        r_or_valid <= 1'b1;
        r_or_y     <= r_sk_y;
        r_or_zero  <= r_sk_zero;
        r_or_err   <= r_sk_err;
        r_sk_valid <= 1'b0;
      end else if (w_accept) begin
        r_or_valid <= 1'b1;
        r_or_y     <= w_idx;
        r_or_zero  <= w_zero;
        r_or_err   <= w_err;
      end else begin
        r_or_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_sk_valid <= 1'b1;
      r_sk_y     <= w_idx;
      r_sk_zero  <= w_zero;
      r_sk_err   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_valid = r_or_valid;
  assign y         = r_or_y;
  assign y_zero    = r_or_zero;
  assign y_err     = r_or_err;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_encoder_42_hs.sv
`default_nettype none
// ============================================================================
// Module  : tb_encoder_42_hs
// Brief   : Directed plus random checks of encoder_42_hs against a FIFO model.
// Revision: 1.0
// ============================================================================
module tb_encoder_42_hs;
  import encdec_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] val;
  logic       in_valid, out_ready, err_clr;

  logic       in_ready, out_valid, y_zero, y_err;
  logic [1:0] y;
  logic [7:0] err_cnt;
  logic       lo_in_ready, lo_out_valid, lo_y_zero, lo_y_err;
  logic [1:0] lo_y;
  logic [7:0] lo_err_cnt;

  always #5 clk = ~clk;

  encoder_42_hs #(.N(4), .PRIO_HIGH(1'b1), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .val(val), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .y_zero(y_zero), .y_err(y_err), .out_valid(out_valid),
    .out_ready(out_ready), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  encoder_42_hs #(.N(4), .PRIO_HIGH(1'b0), .ERR_CNT_W(8)) dut_lo (
    .clk(clk), .rst_n(rst_n), .val(val), .in_valid(in_valid), .in_ready(lo_in_ready),
    .y(lo_y), .y_zero(lo_y_zero), .y_err(lo_y_err), .out_valid(lo_out_valid),
    .out_ready(out_ready), .err_clr(err_clr), .err_cnt(lo_err_cnt)
  );

  typedef struct packed {
    logic [1:0] yh;
    logic [1:0] yl;
    logic       z;
    logic       e;
  } exp_t;

  exp_t        q[$];
  int unsigned mcnt;
  int          checks = 0;
  int          errors = 0;

  // Index from arithmetic on the word value: highest bit = floor(log2 v),
  // lowest bit = log2 of the isolated lowest set bit.
  function automatic exp_t enc(input logic [3:0] v);
    exp_t r;
    int   iv;
    iv   = int'(v);
    r.z  = (v == 4'b0);
    r.e  = ($countones(v) != 1);
    r.yh = (iv == 0) ? 2'd0 : 2'($clog2(iv + 1) - 1);
    r.yl = (iv == 0) ? 2'd0 : 2'($clog2(iv & -iv));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t h;
    chk("out_valid",    32'(out_valid),    32'(q.size() > 0));
    chk("in_ready",     32'(in_ready),     32'(q.size() < 2));
    chk("err_cnt",      32'(err_cnt),      mcnt);
    chk("lo_out_valid", 32'(lo_out_valid), 32'(q.size() > 0));
    chk("lo_in_ready",  32'(lo_in_ready),  32'(q.size() < 2));
    chk("lo_err_cnt",   32'(lo_err_cnt),   mcnt);
    if (q.size() > 0) begin
      h = q[0];
      chk("y",       32'(y),       32'(h.yh));
      chk("y_zero",  32'(y_zero),  32'(h.z));
      chk("y_err",   32'(y_err),   32'(h.e));
      chk("lo_y",    32'(lo_y),    32'(h.yl));
      chk("lo_zero", 32'(lo_y_zero), 32'(h.z));
      chk("lo_err",  32'(lo_y_err),  32'(h.e));
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model at the edge.
  task automatic cyc(input logic [3:0] v, input logic iv, input logic ordy, input logic clr);
    exp_t e;
    bit   acc, emi;
    val = v; in_valid = iv; out_ready = ordy; err_clr = clr;
    @(negedge clk);
    check_outputs();
    acc = iv && (q.size() < 2);
    emi = ordy && (q.size() > 0);
    e   = enc(v);
    if (emi) void'(q.pop_front());
    if (acc) q.push_back(e);
    if (clr) mcnt = 0;
    else if (acc && e.e && mcnt < 255) mcnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rv;
    rst_n = 1'b0; val = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    mcnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_y",         32'(y),         32'd0);
    chk("rst_y_zero",    32'(y_zero),    32'd0);
    chk("rst_y_err",     32'(y_err),     32'd0);
    chk("rst_err_cnt",   32'(err_cnt),   32'd0);
    rst_n = 1'b1;

    // streaming one-hot words
    cyc(4'b0001, 1, 1, 0);
    cyc(4'b0010, 1, 1, 0);
    cyc(4'b0100, 1, 1, 0);
    cyc(4'b1000, 1, 1, 0);
    cyc(4'b0000, 0, 1, 0);

    // zero and multi-hot
    cyc(4'b0000, 1, 1, 0);
    cyc(4'b1010, 1, 1, 0);
    cyc(4'b0000, 0, 1, 0);
    cyc(4'b0000, 0, 1, 0);

    // backpressure then drain
    cyc(4'b0001, 1, 0, 0);
    cyc(4'b0010, 1, 0, 0);
    cyc(4'b0100, 1, 0, 0);
    cyc(4'b0100, 1, 1, 0);
    cyc(4'b0100, 1, 1, 0);
    repeat (3) cyc(4'b0000, 0, 1, 0);

    // counter saturation and clear-over-increment
    repeat (261) cyc(4'b1100, 1, 1, 0);
    cyc(4'b0000, 0, 1, 0);
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    cyc(4'b1100, 1, 1, 1);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    cyc(4'b0000, 0, 1, 0);

    // decoder loopback: sel -> one-hot -> y
    for (int s = 0; s < SEL_N; s++) begin
      cyc(4'(1 << s), 1, 1, 0);
      chk("loop_y",   32'(y),     32'(s));
      chk("loop_err", 32'(y_err), 32'd0);
    end
    cyc(4'b0000, 0, 1, 0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) rv = 4'($urandom_range(0, 15));
      else                           rv = 4'(1 << $urandom_range(0, 3));
      cyc(rv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 49) == 0));
    end
    repeat (3) cyc(4'b0000, 0, 1, 0);

    // reset while both buffer entries are full
    cyc(4'b0000, 1, 1, 0);
    cyc(4'b0001, 1, 0, 0);
    cyc(4'b0010, 1, 0, 0);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_err_cnt",   32'(err_cnt),   32'd0);
    chk("arst_lo_valid",  32'(lo_out_valid), 32'd0);
    q.delete();
    mcnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b0100, 1, 1, 0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_y",     32'(y),         32'd2);
    cyc(4'b0000, 0, 1, 0);
    cyc(4'b0000, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
